// File: rtl/btn_toggle_pulse.sv
//==============================================================================
// btn_toggle_pulse: debounced push-button front end producing one toggle pulse
// per press, with optional auto-repeat while held.          Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_toggle_pulse #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic t_o,
    output logic pressed_o
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic              s1, btn_s;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [REP_W-1:0]  rep, rep_nx;
    logic [REP_W-1:0]  rep_last;
    logic              first, first_nx;
    logic              t_nx, pressed_nx;

    // Two-flop synchronizer for the asynchronous, bouncing button.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn_i;
            btn_s <= s1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            rep       <= '0;
            first     <= 1'b0;
            t_o       <= 1'b0;
            pressed_o <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rep       <= rep_nx;
            first     <= first_nx;
            t_o       <= t_nx;
            pressed_o <= pressed_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rep_nx     = rep;
        first_nx   = first;
        t_nx       = 1'b0;
        pressed_nx = pressed_o;
        rep_last   = first ? DELAY_LAST : PERIOD_LAST;

        case (state)
            IDLE: begin
                pressed_nx = 1'b0;
                if (btn_s) begin
                    state_nx = PRESS_CHK;
                    cnt_nx   = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = HELD;
                    t_nx       = 1'b1;
                    pressed_nx = 1'b1;
                    rep_nx     = '0;
                    first_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nx = RELEASE_CHK;
                    cnt_nx   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rep == rep_last) begin
                        t_nx     = 1'b1;
                        rep_nx   = '0;
                        first_nx = 1'b0;
                    end else begin
                        rep_nx = rep + 1'b1;
                    end
                end
            end
            RELEASE_CHK: begin
                // A short release glitch returns to HELD with the repeat timing frozen.
                if (btn_s) begin
                    state_nx = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = IDLE;
                    pressed_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_toggle_pulse.sv
//==============================================================================
// tb_btn_toggle_pulse: directed table-driven bench for btn_toggle_pulse
// (D=4, RD=6, RP=3) with a downstream T flip-flop model.    Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btn_toggle_pulse;

    localparam int D  = 4;
    localparam int RD = 6;
    localparam int RP = 3;

    typedef struct {
        logic btn;
        logic t;
        logic pressed;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic btn, btn_r;
    logic t, pressed, t_r, pressed_r;
    logic q;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    btn_toggle_pulse #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn), .t_o(t), .pressed_o(pressed)
    );

    btn_toggle_pulse #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_rep (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_r), .t_o(t_r), .pressed_o(pressed_r)
    );

    // Downstream T flip-flop stage driven by the toggle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else if (t) q <= ~q;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic add_run(input logic b, input int n, input logic et, input logic ep);
        for (int i = 0; i < n; i++) vecs.push_back('{btn: b, t: et, pressed: ep});
    endtask

    initial begin
        // Clean press: pulse after edge 6, pressed from edge 6.
        add_run(1'b1, 6, 1'b0, 1'b0);
        add_run(1'b1, 1, 1'b1, 1'b1);
        add_run(1'b1, 3, 1'b0, 1'b1);
        // Clean release: pressed falls at edge 6.
        add_run(1'b0, 6, 1'b0, 1'b1);
        add_run(1'b0, 2, 1'b0, 1'b0);
        // Press bounce 1,1,0,1,1,1,0 then stable 1 from edge 7: pulse after edge 13.
        add_run(1'b1, 2, 1'b0, 1'b0);
        add_run(1'b0, 1, 1'b0, 1'b0);
        add_run(1'b1, 3, 1'b0, 1'b0);
        add_run(1'b0, 1, 1'b0, 1'b0);
        add_run(1'b1, 6, 1'b0, 1'b0);
        add_run(1'b1, 1, 1'b1, 1'b1);
        add_run(1'b1, 2, 1'b0, 1'b1);
        // Release bounce: 2-cycle drop, restore, then clean release from r6.
        add_run(1'b0, 2, 1'b0, 1'b1);
        add_run(1'b1, 4, 1'b0, 1'b1);
        add_run(1'b0, 6, 1'b0, 1'b1);
        add_run(1'b0, 2, 1'b0, 1'b0);

        rst   = 1'b1;
        btn   = 1'b0;
        btn_r = 1'b0;
        tick(); tick(); tick();
        check("reset t_o", t, 1'b0);
        check("reset pressed_o", pressed, 1'b0);
        check("reset rep t_o", t_r, 1'b0);
        check("reset rep pressed_o", pressed_r, 1'b0);
        check("reset q", q, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            btn = vecs[i].btn;
            tick();
            check($sformatf("vec%0d t_o", i), t, vecs[i].t);
            check($sformatf("vec%0d pressed_o", i), pressed, vecs[i].pressed);
        end

        // Auto-repeat: pulses after edges 6, 12, 15, 18, 21, 24.
        btn_r = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            check($sformatf("repeat edge%0d t_o", k), t_r,
                  (k == 6 || k == 12 || k == 15 || k == 18 || k == 21 || k == 24));
            check($sformatf("repeat edge%0d pressed_o", k), pressed_r, k >= 6);
        end
        btn_r = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("repeat released pressed_o", pressed_r, 1'b0);
        check("repeat released t_o", t_r, 1'b0);

        // Reset at edge 4 of a press, released before edge 8 with button held.
        btn = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            check($sformatf("rstpress edge%0d t_o", k), t, 1'b0);
        end
        rst = 1'b1;
        #1;
        check("rst async t_o", t, 1'b0);
        check("rst async pressed_o", pressed, 1'b0);
        for (int k = 5; k <= 7; k++) begin
            tick();
            check($sformatf("rst held edge%0d pressed_o", k), pressed, 1'b0);
        end
        rst = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check($sformatf("postrst p%0d t_o", k), t, k == 6);
            check($sformatf("postrst p%0d pressed_o", k), pressed, k >= 6);
        end

        // Reset asserted mid-cycle while HELD must clear pressed_o without a clock edge.
        #3;
        rst = 1'b1;
        #1;
        check("async rst held pressed_o", pressed, 1'b0);
        check("async rst held t_o", t, 1'b0);
        btn = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();

        // Chain check: three clean presses toggle q 0->1->0->1.
        check("chain q initial", q, 1'b0);
        for (int n = 0; n < 3; n++) begin
            btn = 1'b1;
            for (int k = 0; k < 10; k++) tick();
            btn = 1'b0;
            for (int k = 0; k < 10; k++) tick();
            check($sformatf("chain press%0d q", n + 1), q, (n % 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
